// File: rtl/bit_ser_pkg.sv
// Shared types and limits for the bit serializer that feeds the serial FSM.
package bit_ser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } ser_state_t;

  localparam int SER_GAP_W = 8;
  localparam int SER_MAX_W = 32;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder: accepts words over valid/ready and streams them
// one bit per clock onto x_out, with bit-valid, last-bit and optional idle gap.
module bit_serializer
  import bit_ser_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              x_out,
  output logic              x_valid,
  output logic              x_last,
  output logic              busy
);

  localparam int                    CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [SER_GAP_W-1:0]  GAP_LOAD =
    (GAP_CYCLES > 0) ? SER_GAP_W'(GAP_CYCLES - 1) : '0;

  ser_state_t            state;
  logic [DATA_W-1:0]     shift_reg;
  logic [CNT_W-1:0]      bit_cnt;
  logic [SER_GAP_W-1:0]  gap_cnt;
  logic                  last_bit;
  logic                  take;
  logic [DATA_W-1:0]     shifted;

  function automatic logic head_bit(input logic [DATA_W-1:0] word);
    return MSB_FIRST ? word[DATA_W-1] : word[0];
  endfunction

  // shift_reg always holds the bit currently on x_out at its head position
  assign last_bit = (state == SHIFT) && (bit_cnt == '0);
  assign in_ready = !reset && ((state == IDLE) || (last_bit && (GAP_CYCLES == 0)));
  assign take     = in_valid && in_ready;
  assign shifted  = MSB_FIRST ? (shift_reg << 1) : (shift_reg >> 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      x_out     <= IDLE_LEVEL;
      x_valid   <= 1'b0;
      x_last    <= 1'b0;
      busy      <= 1'b0;
    end else if (take) begin
      // Covers both a fresh start from IDLE and a back-to-back reload
      state     <= SHIFT;
      shift_reg <= in_data;
      bit_cnt   <= CNT_LOAD;
      x_out     <= head_bit(in_data);
      x_valid   <= 1'b1;
      x_last    <= 1'b0;
      busy      <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          x_out   <= IDLE_LEVEL;
          x_valid <= 1'b0;
          x_last  <= 1'b0;
          busy    <= 1'b0;
        end
        SHIFT: begin
          if (bit_cnt != '0) begin
            shift_reg <= shifted;
            bit_cnt   <= bit_cnt - CNT_ONE;
            x_out     <= head_bit(shifted);
            x_last    <= (bit_cnt == CNT_ONE);
          end else if (GAP_CYCLES > 0) begin
            state   <= GAP;
            gap_cnt <= GAP_LOAD;
            x_out   <= IDLE_LEVEL;
            x_valid <= 1'b0;
            x_last  <= 1'b0;
          end else begin
            state   <= IDLE;
            x_out   <= IDLE_LEVEL;
            x_valid <= 1'b0;
            x_last  <= 1'b0;
            busy    <= 1'b0;
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          x_out   <= IDLE_LEVEL;
          x_valid <= 1'b0;
          x_last  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
